// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : shared types and constants for the configurable UART receiver
// Rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_sampler : bit timer with 3-sample majority vote around bit centre
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 restart_i,
  input  logic                 active_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 line_i,
  output logic                 bit_valid_o,
  output logic                 bit_val_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] mid;
  logic [2:0]           smp_q, smp_d;
  logic                 vld_q, vld_d;

  assign mid = div_i >> 1;

  always_comb begin
    cnt_d = cnt_q;
    smp_d = smp_q;
    vld_d = 1'b0;
    if (restart_i || !active_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = (cnt_q == div_i - DIV_WIDTH'(1)) ? '0 : cnt_q + DIV_WIDTH'(1);
      if (cnt_q == mid - DIV_WIDTH'(1)) smp_d[0] = line_i;
      if (cnt_q == mid)                 smp_d[1] = line_i;
      // Decision is presented the cycle after the last sample is captured.
      if (cnt_q == mid + DIV_WIDTH'(1)) begin
        smp_d[2] = line_i;
        vld_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      smp_q <= 3'b111;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      smp_q <= smp_d;
      vld_q <= vld_d;
    end
  end

  assign bit_valid_o = vld_q;
  assign bit_val_o   = maj3(smp_q);

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_cfg : runtime-configurable UART receiver with one-entry holding reg
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [DIV_WIDTH-1:0]  clks_per_bit_i,
  input  logic [3:0]            data_bits_i,
  input  logic [1:0]            parity_i,
  input  logic                  stop2_i,
  input  logic                  ser_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic                  parity_err_o,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  logic sync1_q, sync2_q, s_prev_q;
  logic start_det, restart, done, bit_valid, bit_val, par_exp;

  rx_state_t            state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q;
  logic [3:0]           bits_q;
  parity_t              par_q;
  logic                 stop2_q;

  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  perr_q, perr_d, ferr_q, ferr_d;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d, hperr_q, hperr_d, hferr_q, hferr_d, ovr_q, ovr_d;

  assign start_det = s_prev_q & ~sync2_q;
  assign par_exp   = (par_q == PAR_ODD) ? ~(^shift_q) : ^shift_q;

  uart_rx_sampler #(.DIV_WIDTH(DIV_WIDTH)) u_sampler (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .restart_i   (restart),
    .active_i    (en_i && (state_q != IDLE)),
    .div_i       (div_q),
    .line_i      (sync2_q),
    .bit_valid_o (bit_valid),
    .bit_val_o   (bit_val)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    restart   = 1'b0;
    done      = 1'b0;
    if (!en_i) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: if (start_det) begin
          state_d   = START;
          restart   = 1'b1;
          bit_cnt_d = '0;
          shift_d   = '0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
        end
        START: if (bit_valid) state_d = (bit_val == UART_START_BIT) ? DATA : IDLE;
        DATA: if (bit_valid) begin
          shift_d   = shift_q | (DATA_WIDTH'(bit_val) << bit_cnt_q);
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == bits_q - 4'd1) begin
            bit_cnt_d = '0;
            state_d   = (par_q == PAR_EVEN || par_q == PAR_ODD) ? PARITY : STOP;
          end
        end
        PARITY: if (bit_valid) begin
          perr_d  = (bit_val != par_exp);
          state_d = STOP;
        end
        STOP: if (bit_valid) begin
          ferr_d = ferr_q | (bit_val != UART_STOP_BIT);
          if (stop2_q && bit_cnt_q == 4'd0) begin
            bit_cnt_d = 4'd1;
          end else begin
            // Completing on the decision, not the bit end, keeps an immediate
            // next start edge visible to IDLE.
            bit_cnt_d = '0;
            state_d   = IDLE;
            done      = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    hperr_d = hperr_q;
    hferr_d = hferr_q;
    ovr_d   = 1'b0;
    if (done) begin
      if (!valid_q || data_ready_i) begin
        data_d  = shift_q;
        hperr_d = perr_q;
        hferr_d = ferr_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && data_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      s_prev_q  <= 1'b1;
      state_q   <= IDLE;
      div_q     <= '0;
      bits_q    <= '0;
      par_q     <= PAR_NONE;
      stop2_q   <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      hperr_q   <= 1'b0;
      hferr_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync1_q   <= ser_i;
      sync2_q   <= sync1_q;
      s_prev_q  <= sync2_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      hperr_q   <= hperr_d;
      hferr_q   <= hferr_d;
      ovr_q     <= ovr_d;
      if (restart) begin
        div_q   <= clks_per_bit_i;
        bits_q  <= data_bits_i;
        par_q   <= parity_t'(parity_i);
        stop2_q <= stop2_i;
      end
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign parity_err_o = hperr_q;
  assign frame_err_o  = hferr_q;
  assign overrun_o    = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_rx_cfg : scoreboard bench with a frame-level line model
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [15:0] div = 16'd16;
  logic [3:0]  nbits = 4'd8;
  logic [1:0]  par = 2'd0;
  logic        stop2 = 1'b0;
  logic        ser = 1'b1;
  logic        ready = 1'b0;
  logic [7:0]  data;
  logic        valid, perr, ferr, ovr;

  always #5 clk = ~clk;

  uart_rx_cfg #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .en_i           (en),
    .clks_per_bit_i (div),
    .data_bits_i    (nbits),
    .parity_i       (par),
    .stop2_i        (stop2),
    .ser_i          (ser),
    .data_o         (data),
    .data_valid_o   (valid),
    .data_ready_i   (ready),
    .parity_err_o   (perr),
    .frame_err_o    (ferr),
    .overrun_o      (ovr)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0, n_pass = 0, ovr_seen = 0, ovr_exp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: pops the scoreboard at every accepted word.
  initial forever begin
    @(negedge clk);
    #1;
    if (ovr === 1'b1) ovr_seen++;
    if (rst_n && valid && ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_word: got %0h expected no word", data);
      end else begin
        mon_e = sb.pop_front();
        chk("data", 32'(data), 32'(mon_e.d));
        chk("parity_err", 32'(perr), 32'(mon_e.pe));
        chk("frame_err", 32'(ferr), 32'(mon_e.fe));
      end
    end
  end

  // Line model: start, data LSB first, optional parity, stop bit(s).
  task automatic send_frame(input int d, input int dv, input int nb, input int pm, input bit s2,
                            input bit pflip, input bit st1, input bit st2, input int gap,
                            input int glitch_bit, input int abort_bit, input bit push);
    bit         bits[$];
    logic [7:0] dm;
    bit         pexp;
    exp_t       e;
    dm = 8'(d & ((1 << nb) - 1));
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(dm[i]);
    pexp = (pm == 2) ? ~(^dm) : ^dm;
    if (pm != 0) bits.push_back(pexp ^ pflip);
    bits.push_back(st1);
    if (s2) bits.push_back(st2);
    if (push) begin
      e.d  = dm;
      e.pe = (pm != 0) && pflip;
      e.fe = !st1 || (s2 && !st2);
      sb.push_back(e);
    end
    div = 16'(dv); nbits = 4'(nb); par = 2'(pm); stop2 = s2;
    for (int b = 0; b < bits.size(); b++) begin
      if (b == abort_bit) begin
        ser = 1'b1;
        return;
      end
      if (b == 1) begin
        div = 16'($urandom); nbits = 4'($urandom); par = 2'($urandom); stop2 = 1'($urandom);
      end
      for (int c = 0; c < dv; c++) begin
        ser = (b == glitch_bit && c == dv / 2 + 1) ? ~bits[b] : bits[b];
        @(negedge clk);
      end
    end
    ser = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_valid(input string nm, input int max);
    for (int i = 0; i < max && !valid; i++) @(negedge clk);
    chk(nm, 32'(valid), 32'd1);
  endtask

  task automatic wait_drain(input string nm, input int max);
    for (int i = 0; i < max && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk(nm, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dv, nb, pm;
    bit s2, pf, a, b;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_perr", 32'(perr), 0);
    chk("rst_ferr", 32'(ferr), 0);
    chk("rst_ovr", 32'(ovr), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 0xA5, then a single ready cycle clears valid
    ready = 1'b0;
    send_frame(8'hA5, 16, 8, 0, 0, 0, 1, 1, 4, -1, -1, 1);
    wait_valid("a5_valid", 64);
    chk("a5_held", 32'(data), 32'hA5);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    chk("a5_ready_clears", 32'(valid), 0);
    chk("a5_data_kept", 32'(data), 32'hA5);

    ready = 1'b1;
    send_frame(8'h3C, 16, 8, 1, 0, 1, 1, 1, 8, -1, -1, 1);
    wait_drain("drain_3c", 200);
    send_frame(8'h55, 10, 7, 2, 1, 0, 1, 0, 8, -1, -1, 1);
    wait_drain("drain_55", 200);

    // Short low pulse is rejected as a false start
    div = 16'd16; nbits = 4'd8; par = 2'd0; stop2 = 1'b0;
    ser = 1'b0;
    repeat (3) @(negedge clk);
    ser = 1'b1;
    repeat (40) @(negedge clk);
    chk("false_start_no_valid", 32'(valid), 0);
    send_frame(8'h81, 16, 8, 0, 0, 0, 1, 1, 8, -1, -1, 1);
    wait_drain("drain_81", 200);

    // Back-to-back frames with ready low: second one overruns
    ready = 1'b0;
    send_frame(8'h11, 16, 8, 0, 0, 0, 1, 1, 0, -1, -1, 1);
    send_frame(8'h22, 16, 8, 0, 0, 0, 1, 1, 40, -1, -1, 0);
    ovr_exp++;
    chk("ovr_hold_data", 32'(data), 32'h11);
    chk("ovr_hold_valid", 32'(valid), 1);
    chk("ovr_pulse_cycles", 32'(ovr_seen), 32'(ovr_exp));
    ready = 1'b1;
    wait_drain("drain_11", 200);

    send_frame(8'h00, 16, 8, 0, 0, 0, 1, 1, 8, 1, -1, 1);
    wait_drain("drain_glitch", 200);

    // Enable dropped mid-frame: frame discarded silently
    send_frame(8'hC3, 16, 8, 0, 0, 0, 1, 1, 0, -1, 4, 0);
    en = 1'b0;
    repeat (20) @(negedge clk);
    en = 1'b1;
    repeat (200) @(negedge clk);
    chk("en_drop_no_valid", 32'(valid), 0);

    // Async reset with a held word and a frame in flight
    ready = 1'b0;
    send_frame(8'h5A, 16, 8, 0, 0, 0, 1, 1, 4, -1, -1, 0);
    wait_valid("5a_valid", 64);
    chk("5a_held", 32'(data), 32'h5A);
    send_frame(8'hF0, 16, 8, 0, 0, 0, 1, 1, 0, -1, 5, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 0);
    chk("arst_data", 32'(data), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (200) @(negedge clk);
    chk("arst_no_word", 32'(valid), 0);
    send_frame(8'h81, 16, 8, 0, 0, 0, 1, 1, 8, -1, -1, 1);
    wait_drain("drain_post_rst", 200);

    // Randomised frames and configurations
    for (int k = 0; k < 24; k++) begin
      dv = $urandom_range(6, 24);
      nb = $urandom_range(5, 8);
      pm = $urandom_range(0, 2);
      s2 = 1'($urandom_range(0, 1));
      pf = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 3) != 0);
      b  = ($urandom_range(0, 3) != 0);
      ready = 1'($urandom_range(0, 1));
      send_frame(int'($urandom_range(0, 255)), dv, nb, pm, s2, pf, a, b, 2 * dv, -1, -1, 1);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      ready = 1'b1;
      wait_drain("drain_rand", 400);
    end

    chk("overrun_total", 32'(ovr_seen), 32'(ovr_exp));
    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
